// File: rtl/enigma_pkg.sv
// Shared keyboard constants for the cipher path: PS/2 set-2 prefix bytes,
// the 26 letter make codes, the sequencer state encoding and the
// letter <-> scan-code helpers used by decoders on both sides.
package enigma_pkg;

    localparam int         NUM_LETTERS = 26;
    localparam logic [7:0] SC_BREAK    = 8'hF0;
    localparam logic [7:0] SC_EXT      = 8'hE0;
    localparam logic [4:0] LETTER_NONE = 5'h1F;

    localparam logic [7:0] SC_A = 8'h1C, SC_B = 8'h32, SC_C = 8'h21, SC_D = 8'h23;
    localparam logic [7:0] SC_E = 8'h24, SC_F = 8'h2B, SC_G = 8'h34, SC_H = 8'h33;
    localparam logic [7:0] SC_I = 8'h43, SC_J = 8'h3B, SC_K = 8'h42, SC_L = 8'h4B;
    localparam logic [7:0] SC_M = 8'h3A, SC_N = 8'h31, SC_O = 8'h44, SC_P = 8'h4D;
    localparam logic [7:0] SC_Q = 8'h15, SC_R = 8'h2D, SC_S = 8'h1B, SC_T = 8'h2C;
    localparam logic [7:0] SC_U = 8'h3C, SC_V = 8'h2A, SC_W = 8'h1D, SC_X = 8'h22;
    localparam logic [7:0] SC_Y = 8'h35, SC_Z = 8'h1A;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BRK,
        ST_EXT,
        ST_EXT_BRK
    } kbd_state_t;

    typedef struct packed {
        logic       is_letter;
        logic [4:0] idx;
    } letter_lookup_t;

    // Make code -> {is_letter, 0..25}; non-letters return LETTER_NONE.
    function automatic letter_lookup_t alphabet_to_binary(input logic [7:0] code);
        letter_lookup_t r;
        r.is_letter = 1'b1;
        r.idx       = LETTER_NONE;
        case (code)
            SC_A: r.idx = 5'd0;   SC_B: r.idx = 5'd1;   SC_C: r.idx = 5'd2;
            SC_D: r.idx = 5'd3;   SC_E: r.idx = 5'd4;   SC_F: r.idx = 5'd5;
            SC_G: r.idx = 5'd6;   SC_H: r.idx = 5'd7;   SC_I: r.idx = 5'd8;
            SC_J: r.idx = 5'd9;   SC_K: r.idx = 5'd10;  SC_L: r.idx = 5'd11;
            SC_M: r.idx = 5'd12;  SC_N: r.idx = 5'd13;  SC_O: r.idx = 5'd14;
            SC_P: r.idx = 5'd15;  SC_Q: r.idx = 5'd16;  SC_R: r.idx = 5'd17;
            SC_S: r.idx = 5'd18;  SC_T: r.idx = 5'd19;  SC_U: r.idx = 5'd20;
            SC_V: r.idx = 5'd21;  SC_W: r.idx = 5'd22;  SC_X: r.idx = 5'd23;
            SC_Y: r.idx = 5'd24;  SC_Z: r.idx = 5'd25;
            default: r.is_letter = 1'b0;
        endcase
        return r;
    endfunction

    // Letter index -> make code; out-of-range indices return 8'h00.
    function automatic logic [7:0] binary_to_alphabet(input logic [4:0] idx);
        logic [7:0] c;
        case (idx)
            5'd0:  c = SC_A;  5'd1:  c = SC_B;  5'd2:  c = SC_C;  5'd3:  c = SC_D;
            5'd4:  c = SC_E;  5'd5:  c = SC_F;  5'd6:  c = SC_G;  5'd7:  c = SC_H;
            5'd8:  c = SC_I;  5'd9:  c = SC_J;  5'd10: c = SC_K;  5'd11: c = SC_L;
            5'd12: c = SC_M;  5'd13: c = SC_N;  5'd14: c = SC_O;  5'd15: c = SC_P;
            5'd16: c = SC_Q;  5'd17: c = SC_R;  5'd18: c = SC_S;  5'd19: c = SC_T;
            5'd20: c = SC_U;  5'd21: c = SC_V;  5'd22: c = SC_W;  5'd23: c = SC_X;
            5'd24: c = SC_Y;  5'd25: c = SC_Z;
            default: c = 8'h00;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/scancode_to_letter.sv
// Combinational PS/2 set-2 make-code to letter-index lookup.
module scancode_to_letter
    import enigma_pkg::*;
(
    input  logic [7:0] scan_code,
    output logic       is_letter,
    output logic [4:0] idx
);

    letter_lookup_t lk;

    // Single table lookup so host-side decoders share the same mapping.
    always_comb begin
        lk        = alphabet_to_binary(scan_code);
        is_letter = lk.is_letter;
        idx       = lk.idx;
    end

endmodule

// File: rtl/ps2_keystroke_sequencer.sv
// Turns raw PS/2 bytes into held-letter state plus one-cycle step / release /
// sync_err events. Tracks the F0 (break) and E0 (extended) prefixes and
// abandons a dangling prefix after TIMEOUT_CYCLES idle cycles.
// The release pulse is named key_release because "release" is reserved.
module ps2_keystroke_sequencer
    import enigma_pkg::*;
#(
    parameter bit ALLOW_REPEAT   = 1'b0,
    parameter int TIMEOUT_CYCLES = 2500000,
    parameter int TO_W           = 22
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic [7:0]             scan_code,
    input  logic                   scan_valid,
    output logic [NUM_LETTERS-1:0] letter,
    output logic [4:0]             letter_idx,
    output logic                   key_held,
    output logic                   step,
    output logic                   key_release,
    output logic                   sync_err
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    kbd_state_t             state, state_n;
    logic [TO_W-1:0]        to_cnt, to_cnt_n;
    logic [NUM_LETTERS-1:0] letter_n;
    logic [4:0]             idx_n;
    logic                   held_n, step_n, rel_n, err_n;
    logic                   lk_letter;
    logic [4:0]             lk_idx;

    scancode_to_letter u_lookup (
        .scan_code (scan_code),
        .is_letter (lk_letter),
        .idx       (lk_idx)
    );

    // State, timeout counter and all outputs are plain registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state       <= ST_IDLE;
            to_cnt      <= '0;
            letter      <= '0;
            letter_idx  <= LETTER_NONE;
            key_held    <= 1'b0;
            step        <= 1'b0;
            key_release <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            state       <= state_n;
            to_cnt      <= to_cnt_n;
            letter      <= letter_n;
            letter_idx  <= idx_n;
            key_held    <= held_n;
            step        <= step_n;
            key_release <= rel_n;
            sync_err    <= err_n;
        end
    end

    // Next state/outputs. A byte always takes priority over timeout expiry,
    // and each byte yields at most one of step / release.
    always_comb begin
        state_n  = state;
        to_cnt_n = to_cnt;
        idx_n    = letter_idx;
        held_n   = key_held;
        step_n   = 1'b0;
        rel_n    = 1'b0;
        err_n    = 1'b0;

        if (scan_valid) begin
            to_cnt_n = '0;
            case (state)
                ST_IDLE: begin
                    if (scan_code == SC_EXT) begin
                        state_n = ST_EXT;
                    end else if (scan_code == SC_BREAK) begin
                        state_n = ST_BRK;
                    end else if (lk_letter) begin
                        if (!key_held || lk_idx != letter_idx) begin
                            idx_n  = lk_idx;
                            held_n = 1'b1;
                            step_n = 1'b1;
                        end else if (ALLOW_REPEAT) begin
                            step_n = 1'b1;
                        end
                    end
                end
                ST_BRK: begin
                    if (scan_code == SC_EXT) begin
                        state_n = ST_EXT;
                    end else if (scan_code == SC_BREAK) begin
                        state_n = ST_BRK;
                    end else begin
                        state_n = ST_IDLE;
                        // Breaks of keys other than the held one are dropped.
                        if (lk_letter && key_held && lk_idx == letter_idx) begin
                            idx_n  = LETTER_NONE;
                            held_n = 1'b0;
                            rel_n  = 1'b1;
                        end
                    end
                end
                ST_EXT:  state_n = (scan_code == SC_BREAK) ? ST_EXT_BRK : ST_IDLE;
                default: state_n = ST_IDLE;
            endcase
        end else if (state != ST_IDLE) begin
            if (to_cnt == TO_LAST) begin
                state_n  = ST_IDLE;
                to_cnt_n = '0;
                err_n    = 1'b1;
            end else begin
                to_cnt_n = to_cnt + 1'b1;
            end
        end

        letter_n = held_n ? (NUM_LETTERS'(1) << idx_n) : '0;
    end

endmodule
